// File: rtl/nor2_pkg.sv
// Shared constants and helpers for the nor2_monitor cell and its counters.
package nor2_pkg;

  localparam int unsigned CNT_W_DEFAULT = 16;

  // All-ones value of a w-bit counter; the 64-bit wrap makes w = 64 come out right too.
  function automatic logic [63:0] sat_max(input int unsigned w);
    return (64'd1 << w) - 64'd1;
  endfunction

endpackage

// File: rtl/nor2_monitor_if.sv
// Operand/result bundle of the nor2_monitor cell; master drives operands, slave is the cell.
interface nor2_monitor_if #(
  parameter int unsigned CNT_W = nor2_pkg::CNT_W_DEFAULT
);

  logic             in1;
  logic             in2;
  logic             out;
  logic             out_q;
  logic [CNT_W-1:0] hi_cnt;
  logic [CNT_W-1:0] tog_cnt;

  modport master (
    output in1,
    output in2,
    input  out,
    input  out_q,
    input  hi_cnt,
    input  tog_cnt
  );

  modport slave (
    input  in1,
    input  in2,
    output out,
    output out_q,
    output hi_cnt,
    output tog_cnt
  );

endinterface

// File: rtl/nor2_sat_counter.sv
// Unsigned up-counter with synchronous clear that holds at all-ones instead of wrapping.
module nor2_sat_counter
  import nor2_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(sat_max(CNT_W));

  logic [CNT_W-1:0] count_d, count_q;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != CntMax)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/nor2_monitor.sv
// Two-input NOR with zero-latency and registered outputs. Define NOR2_MONITOR_STATS_EN to
// build the saturating high/toggle activity counters; otherwise they read as constant 0.
module nor2_monitor
  import nor2_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  nor2_monitor_if.slave   bus
);

  logic nor_d, nor_q;

  always_comb begin
    nor_d = ~(bus.in1 | bus.in2);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      nor_q <= 1'b0;
    end else begin
      nor_q <= nor_d;
    end
  end

  assign bus.out   = nor_d;
  assign bus.out_q = nor_q;

`ifdef NOR2_MONITOR_STATS_EN
  logic hi_inc, tog_inc;

  always_comb begin
    hi_inc  = nor_d;
    // A change of the registered value on this edge; nor_q is 0 after reset, so the
    // first post-reset sample only counts when it is 1.
    tog_inc = nor_d ^ nor_q;
  end

  nor2_sat_counter #(
    .CNT_W (CNT_W)
  ) u_hi_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (hi_inc),
    .count (bus.hi_cnt)
  );

  nor2_sat_counter #(
    .CNT_W (CNT_W)
  ) u_tog_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (tog_inc),
    .count (bus.tog_cnt)
  );
`else
  assign bus.hi_cnt  = {CNT_W{1'b0}};
  assign bus.tog_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_nor2_monitor.sv
// Randomized bench for nor2_monitor: two instances (16-bit and 2-bit counters) share operands
// and are checked against a counting reference model.
module tb_nor2_monitor;

`ifdef NOR2_MONITOR_STATS_EN
  localparam bit StatsEn = 1'b1;
`else
  localparam bit StatsEn = 1'b0;
`endif

  logic clk;
  logic reset;

  nor2_monitor_if #(.CNT_W(16)) bus16 ();
  nor2_monitor_if #(.CNT_W(2))  bus2 ();

  nor2_monitor #(
    .CNT_W (16)
  ) u_dut16 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus16)
  );

  nor2_monitor #(
    .CNT_W (2)
  ) u_dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_cmp;
  int unsigned n_err;

  // Reference model: the registered value and plain unbounded event counts.
  logic        a_r, b_r;
  logic        m_q;
  int unsigned m_hi;
  int unsigned m_tog;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_cnt(input int unsigned n, input int unsigned w);
    int unsigned lim;
    lim = (1 << w) - 1;
    if (!StatsEn) return 32'd0;
    return (n > lim) ? lim : n;
  endfunction

  task automatic set_in(input logic a, input logic b);
    a_r = a;
    b_r = b;
    bus16.in1 = a;
    bus16.in2 = b;
    bus2.in1  = a;
    bus2.in2  = b;
  endtask

  task automatic check_comb(input string tag);
    logic e;
    #1;
    e = !(a_r || b_r);
    check_eq({tag, "_out16"}, {31'd0, bus16.out}, {31'd0, e});
    check_eq({tag, "_out2"},  {31'd0, bus2.out},  {31'd0, e});
  endtask

  // Advance one rising edge, update the model, then check all registered outputs.
  task automatic step(input string tag);
    logic v;
    @(posedge clk);
    v = !(a_r || b_r);
    if (reset) begin
      m_q = 1'b0; m_hi = 0; m_tog = 0;
    end else begin
      if (v) m_hi++;
      if (v != m_q) m_tog++;
      m_q = v;
    end
    #1;
    check_eq({tag, "_q16"},   {31'd0, bus16.out_q}, {31'd0, m_q});
    check_eq({tag, "_q2"},    {31'd0, bus2.out_q},  {31'd0, m_q});
    check_eq({tag, "_hi16"},  {16'd0, bus16.hi_cnt},  exp_cnt(m_hi, 16));
    check_eq({tag, "_tog16"}, {16'd0, bus16.tog_cnt}, exp_cnt(m_tog, 16));
    check_eq({tag, "_hi2"},   {30'd0, bus2.hi_cnt},   exp_cnt(m_hi, 2));
    check_eq({tag, "_tog2"},  {30'd0, bus2.tog_cnt},  exp_cnt(m_tog, 2));
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    m_q = 1'b0; m_hi = 0; m_tog = 0;
    reset = 1'b1;
    set_in(1'b0, 1'b0);
    step("rst0");
    step("rst1");

    // Truth table under reset, with explicit constants.
    for (int i = 0; i < 4; i++) begin
      logic [1:0] ab;
      ab = 2'(i);
      @(negedge clk);
      set_in(ab[1], ab[0]);
      #1;
      check_eq("tt_out", {31'd0, bus16.out}, (i == 0) ? 32'd1 : 32'd0);
      step("tt");
    end

    // Registered path: 00 then 11 after reset release.
    @(negedge clk);
    reset = 1'b0;
    set_in(1'b0, 1'b0);
    step("path0");
    check_eq("path0_q", {31'd0, bus16.out_q}, 32'd1);
    @(negedge clk);
    set_in(1'b1, 1'b1);
    step("path1");
    check_eq("path1_q", {31'd0, bus16.out_q}, 32'd0);
    check_eq("path1_tog", {16'd0, bus16.tog_cnt}, StatsEn ? 32'd2 : 32'd0);
    check_eq("path1_hi", {16'd0, bus16.hi_cnt}, StatsEn ? 32'd1 : 32'd0);

    // Random sweep: operands change just after both clock edges.
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      set_in(1'($urandom), 1'($urandom));
      check_comb("swn");
      step("sw");
      set_in(1'($urandom), 1'($urandom));
      check_comb("swp");
    end

    // Saturation of the 2-bit counters.
    @(negedge clk);
    reset = 1'b1;
    step("sat_rst");
    @(negedge clk);
    reset = 1'b0;
    set_in(1'b0, 1'b0);
    for (int i = 0; i < 6; i++) step("sat");
    check_eq("sat_hi2", {30'd0, bus2.hi_cnt}, StatsEn ? 32'd3 : 32'd0);
    check_eq("sat_hi16", {16'd0, bus16.hi_cnt}, StatsEn ? 32'd6 : 32'd0);

    // Reset priority with out=1 and out_q=0 on the reset edge.
    @(negedge clk);
    set_in(1'b1, 1'b1);
    step("pri_pre");
    @(negedge clk);
    set_in(1'b0, 1'b0);
    reset = 1'b1;
    step("pri");
    check_eq("pri_q", {31'd0, bus16.out_q}, 32'd0);
    check_eq("pri_hi", {16'd0, bus16.hi_cnt}, 32'd0);
    check_eq("pri_tog", {16'd0, bus16.tog_cnt}, 32'd0);
    check_eq("pri_out", {31'd0, bus16.out}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
